// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO fed by the store port, drained by a serializer.
// Status (full/empty/level/busy/overflow) and the TX line are all driven from registers.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to become non-empty
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (high); chains straight into START when more data is queued
module uart_tx_fifo #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  ovf_clr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  overflow,
  output logic                  TX
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH        = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0]    BAUD_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  ovf_q;
  logic                  push;
  logic                  pop;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      baud_q;
  logic [CNT_W-1:0]      baud_d;
  logic [2:0]            bit_q;
  logic [2:0]            bit_d;
  logic [7:0]            shreg_q;
  logic [7:0]            shreg_d;
  logic                  tx_q;
  logic                  tx_d;
  logic                  baud_tc;

  // Full is judged on the registered flag, so a push racing a pop while full is rejected.
  assign push = wr_en && !full_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      level_q <= level_d;
      full_q  <= (level_d == LEVEL_MAX);
      empty_q <= (level_d == '0);
      // Set has priority over clear so an overflow in the clearing cycle is not lost.
      if (wr_en && full_q) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign baud_tc = (baud_q == BAUD_TC);

  // tx_d is the line value for the state being entered, so TX changes on the same edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shreg_d = mem[rptr_q];
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 1'b1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            shreg_d = mem[rptr_q];
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = ovf_q;
  assign TX       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit and a 4-entry FIFO.
// A background UART receiver samples TX mid-bit and queues {stop, data} per frame.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       busy;
  logic       overflow;
  logic       TX;

  int checks = 0;
  int errors = 0;
  logic [8:0] rx_q[$];

  uart_tx_fifo #(
    .CLK_HZ(400),
    .BAUD(100),
    .DEPTH_LOG2(2)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .ovf_clr(ovf_clr),
    .full(full),
    .empty(empty),
    .level(level),
    .busy(busy),
    .overflow(overflow),
    .TX(TX)
  );

  always #5 CLK = ~CLK;

  // Start bit seen at its first sample; data bits then sampled at the middle of each bit.
  initial begin : rx_model
    logic [7:0] d;
    logic       s;
    forever begin
      @(negedge CLK);
      if (reset === 1'b1 && TX === 1'b0) begin
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge CLK);
          d[k] = TX;
        end
        repeat (4) @(negedge CLK);
        s = TX;
        rx_q.push_back({s, d});
      end
    end
  end

  task automatic reset_dut();
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    reset   = 1'b0;
    repeat (45) @(negedge CLK);
    rx_q.delete();
    reset = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", TX); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    wr_en = 1'b1; wr_data = 8'h00;
    @(negedge CLK);
    wr_en = 1'b0;
    repeat (10) @(negedge CLK);
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL midframe_tx_before got %b exp 0", TX); end
    #1 reset = 1'b0;
    #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midframe_tx_async got %b exp 1", TX); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy got %b exp 0", busy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midframe_empty got %b exp 1", empty); end
    repeat (45) @(negedge CLK);
    rx_q.delete();
    reset = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_frame();
    logic [9:0] exp_bits;
    int busy_cnt;
    exp_bits = 10'b1101001010;
    busy_cnt = 0;
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge CLK);
    wr_en = 1'b0;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL a5_tx_push_edge got %b exp 1", TX); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL a5_empty got %b exp 0", empty); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL a5_level got %0d exp 1", level); end
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (busy === 1'b1) busy_cnt++;
      if (i == 0) begin
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL a5_popped_level got %0d exp 0", level); end
      end
      if (i % 4 == 0 && i < 40) begin
        checks++;
        if (TX !== exp_bits[i/4]) begin
          errors++; $display("FAIL a5_bit%0d got %b exp %b", i/4, TX, exp_bits[i/4]);
        end
      end
    end
    checks++; if (busy_cnt != 40) begin errors++; $display("FAIL a5_busy_cycles got %0d exp 40", busy_cnt); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h1A5) begin
      errors++; $display("FAIL a5_rx got n=%0d first=%h exp n=1 1a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
    end
    rx_q.delete();
  endtask

  task automatic test_back_to_back();
    int peak, busy_cnt, rises;
    logic prev;
    reset_dut();
    peak = 0; busy_cnt = 0; rises = 0; prev = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      wr_en = 1'b1; wr_data = 8'(e);
      @(negedge CLK);
      if (int'(level) > peak) peak = int'(level);
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && prev === 1'b0) rises++;
      prev = busy;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && prev === 1'b0) rises++;
      prev = busy;
    end
    checks++; if (peak != 2) begin errors++; $display("FAIL b2b_level_peak got %0d exp 2", peak); end
    checks++; if (busy_cnt != 120) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp 120", busy_cnt); end
    checks++; if (rises != 1) begin errors++; $display("FAIL b2b_busy_rises got %0d exp 1", rises); end
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL b2b_rx_count got %0d exp 3", rx_q.size()); end
    for (int k = 0; k < 3; k++) begin
      if (rx_q.size() > k) begin
        checks++;
        if (rx_q[k] !== {1'b1, 8'(k + 1)}) begin
          errors++; $display("FAIL b2b_rx%0d got %h exp %h", k, rx_q[k], {1'b1, 8'(k + 1)});
        end
      end
    end
  endtask

  task automatic test_overflow_fill();
    logic [7:0] b[6];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    reset_dut();
    for (int e = 0; e < 6; e++) begin
      wr_en = 1'b1; wr_data = b[e];
      @(negedge CLK);
      if (e == 1) begin
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL ovf_level_after_pop got %0d exp 1", level); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", busy); end
      end
      if (e == 4) begin
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level_full got %0d exp 4", level); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
      if (e == 5) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level_hold got %0d exp 4", level); end
      end
    end
    wr_en = 1'b0;
    repeat (220) @(negedge CLK);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_rx_count got %0d exp 5", rx_q.size()); end
    for (int k = 0; k < 5; k++) begin
      if (rx_q.size() > k) begin
        checks++;
        if (rx_q[k] !== {1'b1, b[k]}) begin
          errors++; $display("FAIL ovf_rx%0d got %h exp %h", k, rx_q[k], {1'b1, b[k]});
        end
      end
    end
  endtask

  task automatic test_full_pop_collision();
    reset_dut();
    for (int e = 1; e <= 42; e++) begin
      wr_en   = (e <= 5) || (e == 42);
      wr_data = (e == 42) ? 8'h99 : 8'(8'h60 + e);
      @(negedge CLK);
      if (e == 41) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL col_full_before got %b exp 1", full); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL col_level_before got %0d exp 4", level); end
      end
      if (e == 42) begin
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL col_level_after got %0d exp 3", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL col_overflow got %b exp 1", overflow); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL col_full_after got %b exp 0", full); end
      end
    end
    wr_en = 1'b0;
    ovf_clr = 1'b1;
    @(negedge CLK);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL col_ovf_clr got %b exp 0", overflow); end
    repeat (200) @(negedge CLK);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL col_rx_count got %0d exp 5", rx_q.size()); end
    for (int k = 0; k < 5; k++) begin
      if (rx_q.size() > k) begin
        checks++;
        if (rx_q[k] !== {1'b1, 8'(8'h61 + k)}) begin
          errors++; $display("FAIL col_rx%0d got %h exp %h", k, rx_q[k], {1'b1, 8'(8'h61 + k)});
        end
      end
    end
  endtask

  task automatic test_wrap();
    int t;
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      t = 0;
      while (full === 1'b1 && t < 200) begin
        @(negedge CLK);
        t++;
      end
      if (t >= 200) begin
        checks++; errors++; $display("FAIL wrap_full_timeout push %0d got full exp not full", k);
      end
      wr_en = 1'b1; wr_data = (k % 2 == 1) ? 8'h00 : 8'hFF;
      @(negedge CLK);
      wr_en = 1'b0;
    end
    t = 0;
    while (rx_q.size() < 10 && t < 800) begin
      @(negedge CLK);
      t++;
    end
    checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL wrap_rx_count got %0d exp 10", rx_q.size()); end
    for (int k = 0; k < 10; k++) begin
      if (rx_q.size() > k) begin
        checks++;
        if (rx_q[k] !== ((k % 2 == 1) ? 9'h100 : 9'h1FF)) begin
          errors++; $display("FAIL wrap_rx%0d got %h exp %h", k, rx_q[k], (k % 2 == 1) ? 9'h100 : 9'h1FF);
        end
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got %b exp 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow_fill();
    test_full_pop_collision();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
